wb_wom_stage: RTL and testbench
===============================

Name: wb_wom_stage

Overview:
Stage directly downstream of Execution in the vector CPU.
- Takes the four 32-bit lane results r1..r4 and the control/address fields carried through the ID/EXE pipe.
- Registers the pixel-register writeback back to Decode.
- Buffers write-only-memory (WOM) stores in a small FIFO and serializes each 4-lane store into four byte writes to the output pixel memory over a valid/ready handshake.

Parameters:
DEPTH, 4, WOM store FIFO entries (power of two, >=2)
ADDR_W, 32, WOM address width
DATA_W, 32, lane result width
PIX_W, 8, output pixel width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
wr_pxl_in  in  1  EXE-stage pixel-register write enable
wr_pos_in  in  1  EXE-stage pixel-position write flag
wr_wom_in  in  1  EXE-stage WOM store request
wom_addr_in  in  ADDR_W  WOM base byte address of store
r1, r2, r3, r4  in  DATA_W  lane results from Execution
we_pxl  out  1  registered writeback enable to Decode
wr_pos_pxl  out  1  registered position flag to Decode
wdp1, wdp2, wdp3, wdp4  out  DATA_W  registered writeback data (= r1..r4)
stall  out  1  FIFO full; upstream must hold wr_wom_in
overflow  out  1  sticky: a store was dropped
mem_valid  out  1  byte write valid
mem_ready  in  1  memory accepts byte
mem_addr  out  ADDR_W  byte address
mem_data  out  PIX_W  byte data

Behaviour:
Reset:
- All outputs 0. FIFO empty, count 0. FSM in IDLE. overflow cleared.
- Reset mid-transfer abandons the current handshake; mem_valid is 0 after the reset edge.

Writeback path (1-cycle latency, no stall):
- Every edge: we_pxl<=wr_pxl_in, wr_pos_pxl<=wr_pos_in, wdpN<=rN.
- Independent of WOM FIFO state.

Push:
- wr_wom_in && count<DEPTH pushes {wom_addr_in, r1..r4}.
- stall = (count==DEPTH), combinational from registered count.
- wr_wom_in while count==DEPTH drops the store and sets overflow, even if a pop occurs the same cycle. overflow stays set until rst.
- Simultaneous push and pop when not full leaves count unchanged.

Serializer FSM:
- IDLE: mem_valid=0. If FIFO non-empty, next state is SEND with lane=0. A store pushed at edge t drives mem_valid at t+1 at the earliest.
- SEND: mem_valid=1, mem_addr=head.addr+lane (mod 2^ADDR_W), mem_data=pix(head.r[lane]).
  - While mem_valid && !mem_ready, addr and data hold stable.
  - On handshake with lane<3: lane++.
  - On handshake with lane==3: pop head. If the FIFO still holds an entry after the pop, stay in SEND with lane=0 (back-to-back, no bubble); else go to IDLE.
- Lane order is r1, r2, r3, r4 at addresses base+0..base+3.

Pixel conversion pix():
- Input is signed DATA_W.
- With saturation (see below): <0 gives 0; >255 gives 255; else the low 8 bits.

Optional Feature:
WOM_SAT_EN:
- Defined: pix() saturates as above.
- Undefined: pix() = rN[PIX_W-1:0] (truncation); no compare logic is generated.
- Writeback path unaffected either way.

Test Plan:
1. Reset then idle, mem_ready=1 → we_pxl=0, mem_valid=0, stall=0, overflow=0 for 10 cycles.
2. wr_pxl_in=1, r1..r4=5,6,7,8 for one cycle → next cycle we_pxl=1, wdp1..4=5,6,7,8; following cycle we_pxl=0.
3. Store addr=0x100, r=10,20,30,40, mem_ready=1 → mem_valid cycles t+1..t+4 with (0x100,10),(0x101,20),(0x102,30),(0x103,40); then mem_valid=0.
4. Store r=-3,300,255,128 with WOM_SAT_EN → bytes 0,255,255,128; without the macro → 0xFD,0x2C,0xFF,0x80.
5. mem_ready=0, five consecutive stores → stall=1 after 4th push; 5th dropped, overflow=1. Raise mem_ready → exactly 16 byte writes, then stall=0 and overflow stays 1.
6. mem_ready toggling 1,0,1,0 during a store with addr=0xFFFFFFFE → addr/data held while ready=0; addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Assert rst mid-store → mem_valid=0 next cycle and FIFO empty.

Source files
------------

// File: rtl/wb_wom_stage.sv
// Writeback / write-only-memory stage: registers the pixel writeback to Decode
// and serializes queued 4-lane WOM stores into byte writes. Define WOM_SAT_EN for saturating pixel conversion.
module wb_wom_stage #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_pxl_in,
    input  logic              wr_pos_in,
    input  logic              wr_wom_in,
    input  logic [ADDR_W-1:0] wom_addr_in,
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] r2,
    input  logic [DATA_W-1:0] r3,
    input  logic [DATA_W-1:0] r4,
    output logic              we_pxl,
    output logic              wr_pos_pxl,
    output logic [DATA_W-1:0] wdp1,
    output logic [DATA_W-1:0] wdp2,
    output logic [DATA_W-1:0] wdp3,
    output logic [DATA_W-1:0] wdp4,
    output logic              stall,
    output logic              overflow,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state_q, state_d;
    logic [1:0] lane_q, lane_d;

    logic [ADDR_W-1:0]         addr_mem [DEPTH];
    logic [3:0][PIX_W-1:0]     pix_mem  [DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          count;

    logic [DATA_W-1:0]         lanes [4];
    logic [3:0][PIX_W-1:0]     pix_in;
    logic                      push, pop;

    assign lanes[0] = r1;
    assign lanes[1] = r2;
    assign lanes[2] = r3;
    assign lanes[3] = r4;

`ifdef WOM_SAT_EN
    localparam logic [DATA_W-1:0] PIX_MAX = DATA_W'((2 ** PIX_W) - 1);

    // Signed clamp to [0, 2^PIX_W-1]; sign bit set means negative.
    function automatic logic [PIX_W-1:0] pix_sat(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1])
            return '0;
        else if (v > PIX_MAX)
            return '1;
        else
            return v[PIX_W-1:0];
    endfunction

    always_comb begin
        pix_in = '0;
        for (int i = 0; i < 4; i++) pix_in[i] = pix_sat(lanes[i]);
    end
`else
    always_comb begin
        pix_in = '0;
        for (int i = 0; i < 4; i++) pix_in[i] = lanes[i][PIX_W-1:0];
    end
`endif

    assign stall = (count == FULL);
    assign push  = wr_wom_in && !stall;
    assign pop   = (state_q == SEND) && mem_ready && (lane_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            we_pxl     <= 1'b0;
            wr_pos_pxl <= 1'b0;
            wdp1       <= '0;
            wdp2       <= '0;
            wdp3       <= '0;
            wdp4       <= '0;
        end else begin
            we_pxl     <= wr_pxl_in;
            wr_pos_pxl <= wr_pos_in;
            wdp1       <= r1;
            wdp2       <= r2;
            wdp3       <= r3;
            wdp4       <= r4;
        end
    end

    // Pixels are converted on entry, so the queue only holds byte-wide lanes.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= wom_addr_in;
            pix_mem[wr_ptr]  <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (wr_wom_in && stall) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    // A store arriving on the same edge as the last pop keeps SEND busy with no bubble.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    state_d = SEND;
                    lane_d  = 2'd0;
                end
            end
            SEND: begin
                if (mem_ready) begin
                    if (lane_q != 2'd3) begin
                        lane_d = lane_q + 2'd1;
                    end else begin
                        lane_d = 2'd0;
                        if (count > CNT_W'(1) || push)
                            state_d = SEND;
                        else
                            state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = 2'd0;
            end
        endcase
    end

    assign mem_valid = (state_q == SEND);
    assign mem_addr  = mem_valid ? addr_mem[rd_ptr] + ADDR_W'(lane_q) : '0;
    assign mem_data  = mem_valid ? pix_mem[rd_ptr][lane_q] : '0;

endmodule

// File: tb/tb_wb_wom_stage.sv
// Directed self-checking bench for wb_wom_stage; expected pixel bytes follow
// WOM_SAT_EN when that macro is defined for the build.
module tb_wb_wom_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_pxl_in, wr_pos_in, wr_wom_in;
    logic [31:0] wom_addr_in;
    logic [31:0] r1, r2, r3, r4;
    logic        we_pxl, wr_pos_pxl;
    logic [31:0] wdp1, wdp2, wdp3, wdp4;
    logic        stall, overflow;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_wom_stage #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .PIX_W(8)) dut (
        .clk(clk), .rst(rst),
        .wr_pxl_in(wr_pxl_in), .wr_pos_in(wr_pos_in), .wr_wom_in(wr_wom_in),
        .wom_addr_in(wom_addr_in),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .we_pxl(we_pxl), .wr_pos_pxl(wr_pos_pxl),
        .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
        .stall(stall), .overflow(overflow),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic wom, input logic [31:0] addr,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d);
        wr_wom_in   = wom;
        wom_addr_in = addr;
        r1 = a; r2 = b; r3 = c; r4 = d;
    endtask

    logic [7:0]  exp_pix [4];
    logic [31:0] exp_addr;
    logic [7:0]  exp_data;
    int          nbytes;

    initial begin
        rst = 1'b1; wr_pxl_in = 1'b0; wr_pos_in = 1'b0; mem_ready = 1'b1;
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 10; i++) begin
            check_output("idle_we_pxl", 64'(we_pxl), 64'd0);
            check_output("idle_mem_valid", 64'(mem_valid), 64'd0);
            check_output("idle_stall", 64'(stall), 64'd0);
            check_output("idle_overflow", 64'(overflow), 64'd0);
            step();
        end

        $display("[TB] writeback path");
        wr_pxl_in = 1'b1; wr_pos_in = 1'b1;
        apply_stimulus(1'b0, 32'h0, 32'd5, 32'd6, 32'd7, 32'd8);
        step();
        wr_pxl_in = 1'b0; wr_pos_in = 1'b0;
        check_output("wb_we_pxl", 64'(we_pxl), 64'd1);
        check_output("wb_wr_pos", 64'(wr_pos_pxl), 64'd1);
        check_output("wb_wdp1", 64'(wdp1), 64'd5);
        check_output("wb_wdp2", 64'(wdp2), 64'd6);
        check_output("wb_wdp3", 64'(wdp3), 64'd7);
        check_output("wb_wdp4", 64'(wdp4), 64'd8);
        check_output("wb_no_wom", 64'(mem_valid), 64'd0);
        step();
        check_output("wb_we_pxl_off", 64'(we_pxl), 64'd0);

        $display("[TB] single store");
        apply_stimulus(1'b1, 32'h100, 32'd10, 32'd20, 32'd30, 32'd40);
        step();
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        check_output("st_latency", 64'(mem_valid), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check_output("st_valid", 64'(mem_valid), 64'd1);
            check_output("st_addr", 64'(mem_addr), 64'(32'h100 + i));
            check_output("st_data", 64'(mem_data), 64'(10 * (i + 1)));
            step();
        end
        check_output("st_done", 64'(mem_valid), 64'd0);

        $display("[TB] pixel conversion");
`ifdef WOM_SAT_EN
        exp_pix[0] = 8'd0;    exp_pix[1] = 8'd255; exp_pix[2] = 8'd255; exp_pix[3] = 8'd128;
`else
        exp_pix[0] = 8'hFD;   exp_pix[1] = 8'h2C;  exp_pix[2] = 8'hFF;  exp_pix[3] = 8'h80;
`endif
        apply_stimulus(1'b1, 32'h200, 32'hFFFF_FFFD, 32'd300, 32'd255, 32'd128);
        step();
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            check_output("pix_addr", 64'(mem_addr), 64'(32'h200 + i));
            check_output("pix_data", 64'(mem_data), 64'(exp_pix[i]));
            step();
        end
        check_output("pix_done", 64'(mem_valid), 64'd0);

        $display("[TB] fill and overflow");
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 32'h300 + 32'(16 * k), 32'(16 * k + 1), 32'(16 * k + 2),
                           32'(16 * k + 3), 32'(16 * k + 4));
            step();
            check_output("fill_stall", 64'(stall), 64'(k >= 3));
            check_output("fill_overflow", 64'(overflow), 64'(k == 4));
        end
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        check_output("fill_hold_stall", 64'(stall), 64'd1);
        check_output("fill_hold_addr", 64'(mem_addr), 64'h300);
        mem_ready = 1'b1;
        nbytes = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (mem_valid) begin
                exp_addr = 32'h300 + 32'(16 * (nbytes / 4)) + 32'(nbytes % 4);
                exp_data = 8'(16 * (nbytes / 4) + (nbytes % 4) + 1);
                check_output("drain_addr", 64'(mem_addr), 64'(exp_addr));
                check_output("drain_data", 64'(mem_data), 64'(exp_data));
                nbytes++;
            end
            step();
        end
        check_output("drain_count", 64'(nbytes), 64'd16);
        check_output("drain_stall", 64'(stall), 64'd0);
        check_output("drain_overflow_sticky", 64'(overflow), 64'd1);

        $display("[TB] backpressure, address wrap and reset");
        mem_ready = 1'b0;
        apply_stimulus(1'b1, 32'hFFFF_FFFE, 32'd1, 32'd2, 32'd3, 32'd4);
        step();
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        check_output("wrap_a0", 64'(mem_addr), 64'hFFFF_FFFE);
        check_output("wrap_d0", 64'(mem_data), 64'd1);
        mem_ready = 1'b1;
        step();
        check_output("wrap_a1", 64'(mem_addr), 64'hFFFF_FFFF);
        check_output("wrap_d1", 64'(mem_data), 64'd2);
        mem_ready = 1'b0;
        apply_stimulus(1'b1, 32'h500, 32'd9, 32'd9, 32'd9, 32'd9);
        step();
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        check_output("hold_a1", 64'(mem_addr), 64'hFFFF_FFFF);
        check_output("hold_d1", 64'(mem_data), 64'd2);
        mem_ready = 1'b1;
        step();
        check_output("wrap_a2", 64'(mem_addr), 64'h0);
        check_output("wrap_d2", 64'(mem_data), 64'd3);
        mem_ready = 1'b0;
        step();
        check_output("hold_a2", 64'(mem_addr), 64'h0);
        check_output("hold_d2", 64'(mem_data), 64'd3);
        mem_ready = 1'b1;
        step();
        check_output("wrap_a3", 64'(mem_addr), 64'h1);
        check_output("wrap_d3", 64'(mem_data), 64'd4);
        check_output("pre_rst_overflow", 64'(overflow), 64'd1);
        mem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_ready = 1'b1;
        check_output("rst_mem_valid", 64'(mem_valid), 64'd0);
        check_output("rst_overflow", 64'(overflow), 64'd0);
        check_output("rst_stall", 64'(stall), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("rst_fifo_empty", 64'(mem_valid), 64'd0);
        end

        $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
